// File: rtl/ram_arb_pkg.sv
// Shared constants and FSM encoding for the two-requester RAM port arbiter.
package ram_arb_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DEF_AW  = 5;
    localparam int unsigned DEF_DW  = 4;

    typedef logic [0:0] state_t;

    localparam state_t StIdle   = 1'b0;
    localparam state_t StAccess = 1'b1;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester not served last wins.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic [NUM_REQ-1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single read/write port of the inferred RAM between two requesters,
// one access per grant, returning read data to the owner two cycles after ready.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  ram_we,
    output logic [AW-1:0]         ram_a,
    output logic [DW-1:0]         ram_di,
    input  logic [DW-1:0]         ram_spo
);

    state_t               state_q, state_d;
    logic                 last_grant_q;
    logic                 cmd_we_q;
    logic                 cmd_id_q;
    logic [AW-1:0]        cmd_addr_q;
    logic [DW-1:0]        cmd_wdata_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [DW-1:0]        rsp_rdata_q;
    logic [NUM_REQ-1:0]   gnt;
    logic                 grant_id;
    logic                 accept;

    rr_arb2 u_rr_arb2 (
        .req  (req_valid),
        .last (last_grant_q),
        .gnt  (gnt)
    );

    assign grant_id = gnt[1];
    assign accept   = (state_q == StIdle) && (|req_valid);

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    req_ready = gnt;
                    state_d   = StAccess;
                end
            end
            StAccess: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cmd_we_q     <= 1'b0;
            cmd_id_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= '0;
            if (accept) begin
                cmd_we_q    <= req_we[grant_id];
                cmd_id_q    <= grant_id;
                cmd_addr_q  <= req_addr[grant_id*AW +: AW];
                cmd_wdata_q <= req_wdata[grant_id*DW +: DW];
            end
            if (state_q == StAccess) begin
                last_grant_q <= cmd_id_q;
                if (!cmd_we_q) begin
                    // spo is the asynchronous read of ram_a, so it is valid this cycle
                    rsp_rdata_q <= ram_spo;
                    rsp_valid_q <= id_to_onehot(cmd_id_q);
                end
            end
        end
    end

    // ram_we follows the state register so an async reset aborts a write at once
    assign ram_we    = (state_q == StAccess) && cmd_we_q;
    assign ram_a     = cmd_addr_q;
    assign ram_di    = cmd_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 32x4 RAM on the shared port.
module tb_ram_port_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 4;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]    req_ready;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_spo;

    logic [DW-1:0] mem [32];
    logic          we_prev;

    int n_tests;
    int n_fail;

    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_we    (ram_we),
        .ram_a     (ram_a),
        .ram_di    (ram_di),
        .ram_spo   (ram_spo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, asynchronous read
    assign ram_spo = mem[ram_a];
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_di;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // A write must hold ram_we for exactly one cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            we_prev <= 1'b0;
        end else begin
            if (ram_we) check("ram_we_single_cycle", {7'd0, we_prev}, 8'd0);
            we_prev <= ram_we;
        end
    end

    typedef struct {
        logic [1:0]    v;
        logic [1:0]    we;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [1:0]    rdy;
        logic [1:0]    rsp;
        logic [DW-1:0] rdata;
        logic          rwe;
        logic [AW-1:0] ra;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] we,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic [1:0] rdy, input logic [1:0] rsp,
                                input logic [DW-1:0] rdata, input logic rwe,
                                input logic [AW-1:0] ra);
        vec_t t;
        t.v = v; t.we = we; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
        t.rdy = rdy; t.rsp = rsp; t.rdata = rdata; t.rwe = rwe; t.ra = ra;
        return t;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    vec_t vecs [16];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive(2'b00, 2'b00, 5'd0, 5'd0, 4'h0, 4'h0);
        for (int i = 0; i < 32; i++) mem[i] = 4'h0;
        mem[2] = 4'hC;
        mem[4] = 4'h7;

        // One row per cycle: write/read req0 addr 1, cross-requester RAW on addr 3,
        // sustained contention, then a request withdrawn during ACCESS.
        vecs[0]  = mk(2'b01, 2'b01, 5'd1, 5'd0, 4'hA, 4'h0, 2'b01, 2'b00, 4'h0, 1'b0, 5'd0);
        vecs[1]  = mk(2'b00, 2'b00, 5'd0, 5'd0, 4'h0, 4'h0, 2'b00, 2'b00, 4'h0, 1'b1, 5'd1);
        vecs[2]  = mk(2'b01, 2'b00, 5'd1, 5'd0, 4'h0, 4'h0, 2'b01, 2'b00, 4'h0, 1'b0, 5'd1);
        vecs[3]  = mk(2'b00, 2'b00, 5'd0, 5'd0, 4'h0, 4'h0, 2'b00, 2'b00, 4'h0, 1'b0, 5'd1);
        vecs[4]  = mk(2'b10, 2'b10, 5'd0, 5'd3, 4'h0, 4'hF, 2'b10, 2'b01, 4'hA, 1'b0, 5'd1);
        vecs[5]  = mk(2'b00, 2'b00, 5'd0, 5'd0, 4'h0, 4'h0, 2'b00, 2'b00, 4'h0, 1'b1, 5'd3);
        vecs[6]  = mk(2'b01, 2'b00, 5'd3, 5'd0, 4'h0, 4'h0, 2'b01, 2'b00, 4'h0, 1'b0, 5'd3);
        vecs[7]  = mk(2'b11, 2'b00, 5'd2, 5'd3, 4'h0, 4'h0, 2'b00, 2'b00, 4'h0, 1'b0, 5'd3);
        vecs[8]  = mk(2'b11, 2'b00, 5'd2, 5'd3, 4'h0, 4'h0, 2'b10, 2'b01, 4'hF, 1'b0, 5'd3);
        vecs[9]  = mk(2'b11, 2'b00, 5'd2, 5'd3, 4'h0, 4'h0, 2'b00, 2'b00, 4'h0, 1'b0, 5'd3);
        vecs[10] = mk(2'b11, 2'b00, 5'd2, 5'd3, 4'h0, 4'h0, 2'b01, 2'b10, 4'hF, 1'b0, 5'd3);
        vecs[11] = mk(2'b11, 2'b00, 5'd2, 5'd3, 4'h0, 4'h0, 2'b00, 2'b00, 4'h0, 1'b0, 5'd2);
        vecs[12] = mk(2'b11, 2'b00, 5'd2, 5'd3, 4'h0, 4'h0, 2'b10, 2'b01, 4'hC, 1'b0, 5'd2);
        vecs[13] = mk(2'b10, 2'b10, 5'd0, 5'd7, 4'h0, 4'h3, 2'b00, 2'b00, 4'h0, 1'b0, 5'd3);
        vecs[14] = mk(2'b00, 2'b00, 5'd0, 5'd0, 4'h0, 4'h0, 2'b00, 2'b10, 4'hF, 1'b0, 5'd3);
        vecs[15] = mk(2'b00, 2'b00, 5'd0, 5'd0, 4'h0, 4'h0, 2'b00, 2'b00, 4'h0, 1'b0, 5'd3);

        // Reset values while rst_n is low
        #3;
        check("rst_ready",  {6'd0, req_ready}, 8'h00);
        check("rst_rsp",    {6'd0, rsp_valid}, 8'h00);
        check("rst_rdata",  {4'd0, rsp_rdata}, 8'h00);
        check("rst_ram_we", {7'd0, ram_we},    8'h00);
        check("rst_ram_a",  {3'd0, ram_a},     8'h00);
        check("rst_ram_di", {4'd0, ram_di},    8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // First contention after reset goes to requester 0
        @(posedge clk); #1;
        drive(2'b11, 2'b00, 5'd2, 5'd3, 4'h0, 4'h0);
        @(negedge clk);
        check("first_cont_ready", {6'd0, req_ready}, 8'h01);
        @(posedge clk); #1;
        drive(2'b00, 2'b00, 5'd0, 5'd0, 4'h0, 4'h0);
        @(negedge clk);
        check("first_cont_access_ready", {6'd0, req_ready}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        check("first_cont_rsp",   {6'd0, rsp_valid}, 8'h01);
        check("first_cont_rdata", {4'd0, rsp_rdata}, 8'h0C);

        // Fresh reset so the table starts from last_grant=1
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].v, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), {6'd0, req_ready}, {6'd0, vecs[i].rdy});
            check($sformatf("vec%0d_rsp", i),   {6'd0, rsp_valid}, {6'd0, vecs[i].rsp});
            check($sformatf("vec%0d_ram_we", i), {7'd0, ram_we},   {7'd0, vecs[i].rwe});
            check($sformatf("vec%0d_ram_a", i), {3'd0, ram_a},     {3'd0, vecs[i].ra});
            if (vecs[i].rsp != 2'b00)
                check($sformatf("vec%0d_rdata", i), {4'd0, rsp_rdata}, {4'd0, vecs[i].rdata});
        end

        // Reset asserted during a write of 5 to addr 4 aborts it
        @(posedge clk); #1;
        drive(2'b01, 2'b01, 5'd4, 5'd0, 4'h5, 4'h0);
        @(negedge clk);
        check("abort_ready", {6'd0, req_ready}, 8'h01);
        @(posedge clk); #1;
        drive(2'b00, 2'b00, 5'd0, 5'd0, 4'h0, 4'h0);
        check("abort_we_before", {7'd0, ram_we}, 8'h01);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_we_after",  {7'd0, ram_we},    8'h00);
        check("abort_rsp_after", {6'd0, rsp_valid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Addr 4 must still hold its old value
        @(posedge clk); #1;
        drive(2'b01, 2'b00, 5'd4, 5'd0, 4'h0, 4'h0);
        @(negedge clk);
        check("abort_read_ready", {6'd0, req_ready}, 8'h01);
        @(posedge clk); #1;
        drive(2'b00, 2'b00, 5'd0, 5'd0, 4'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        check("abort_read_rsp",   {6'd0, rsp_valid}, 8'h01);
        check("abort_read_rdata", {4'd0, rsp_rdata}, 8'h07);

        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
